// File: rtl/shift_add_multiply.sv
// Iterative shift-and-add multiplier, unsigned or two's complement per operation.
// Latency: done and p valid WIDTH+1 edges after the edge that accepts start.
// Backpressure: start is accepted only in IDLE/DONE; it is ignored while busy.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all state and aborts any op
//   start        request; sampled only when idle or done
//   signed_mode  1 = x,y are two's complement; sampled with start
//   x, y         multiplicand / multiplier (WIDTH bits); sampled with start
//   p            2*WIDTH-bit product, registered; held until the next completion
//   busy         high while an operation is iterating or fixing up the sign
//   done         level, high from completion until the next accepted start
module shift_add_multiply #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    // Counter must hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   mc;        // multiplicand magnitude
    logic [WIDTH-1:0]   mp;        // multiplier magnitude, consumed LSB first
    logic [WIDTH-1:0]   acc_hi;    // upper half of the running product
    logic [WIDTH-1:0]   acc_lo;    // lower half, filled from the top as acc_hi shifts out
    logic               neg;       // final product must be negated

    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_full;
    logic               accept;
    logic               last_step;

    // Magnitudes of the operands. The most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number, so no overflow case.
    always_comb begin
        x_mag = x;
        y_mag = y;
        if (signed_mode && x[WIDTH-1]) begin
            x_mag = {WIDTH{1'b0}} - x;
        end
        if (signed_mode && y[WIDTH-1]) begin
            y_mag = {WIDTH{1'b0}} - y;
        end
    end

    // One partial-product step: conditionally add mc into the upper half with a
    // carry bit, then the whole {carry, acc_hi, acc_lo} word shifts right by one.
    always_comb begin
        sum = {1'b0, acc_hi};
        if (mp[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mc};
        end
    end

    assign acc_full  = {acc_hi, acc_lo};
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (counter == CW'(1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. Operand registers only load on an accepted start, so changes on
    // x/y/signed_mode and extra start pulses during an operation are harmless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
            mc      <= '0;
            mp      <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            p       <= '0;
        end else begin
            if (accept) begin
                mc      <= x_mag;
                mp      <= y_mag;
                neg     <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                acc_hi  <= '0;
                acc_lo  <= '0;
                counter <= CW'(WIDTH);
            end else if (state == RUN) begin
                acc_hi  <= sum[WIDTH:1];
                acc_lo  <= {sum[0], acc_lo[WIDTH-1:1]};
                mp      <= mp >> 1;
                counter <= counter - CW'(1);
            end

            // p only moves here, so it holds the previous result while busy.
            if (state == FIX) begin
                if (neg) begin
                    p <= {(2*WIDTH){1'b0}} - acc_full;
                end else begin
                    p <= acc_full;
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiply.sv
module tb_shift_add_multiply;

    localparam int W = 8;

    logic           clock;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;

    int tests;
    int fails;

    shift_add_multiply #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .x           (x),
        .y           (y),
        .p           (p),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: extend each operand to 2W bits by its interpretation and
    // multiply; the low 2W bits are the exact product in either mode.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = sm ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sm ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Issues one operation starting at the current negedge and watches it to
    // completion. pa/pb: iterations at which a stray start with random operands is
    // pulsed. hold: raise start in the last busy cycle and leave it high on return.
    // edges: posedges after the accepting edge until done was seen (-1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input int pa, input int pb, input bit hold,
                          output logic [2*W-1:0] res, output int edges,
                          output int busy_cyc, output bit held_ok);
        logic [2*W-1:0] p_before;
        p_before    = p;
        held_ok     = 1'b1;
        busy_cyc    = 0;
        edges       = -1;
        x           = a;
        y           = b;
        signed_mode = sm;
        start       = 1'b1;
        for (int it = 1; it <= 40; it++) begin
            @(negedge clock);
            if (done) begin
                edges = it - 1;
                break;
            end
            if (busy) busy_cyc++;
            if (p !== p_before) held_ok = 1'b0;
            // Operands wander every busy cycle; they must not matter.
            x           = W'($urandom);
            y           = W'($urandom);
            signed_mode = 1'($urandom);
            if (it == pa || it == pb) begin
                start = 1'b1;
            end else if (hold && it >= 9) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        res = p;
    endtask

    task automatic test_reset();
        logic [2*W-1:0] r;
        int e, bc;
        bit h;
        reset = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        signed_mode = 1'b0;
        repeat (2) @(negedge clock);
        tests++; if (p !== 16'h0000) begin fails++; $display("FAIL reset_p got=%h exp=0000", p); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
        @(negedge clock);
        // Leave a non-zero result in p, then abort a second op mid-run.
        run_op(8'd200, 8'd100, 1'b0, 0, 0, 1'b0, r, e, bc, h);
        tests++; if (r !== model(8'd200, 8'd100, 1'b0)) begin
            fails++; $display("FAIL pre_abort_p got=%h exp=%h", r, model(8'd200, 8'd100, 1'b0));
        end
        start = 1'b0;
        @(negedge clock);
        x = 8'd77;
        y = 8'd99;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_running got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        tests++; if (p !== 16'h0000) begin fails++; $display("FAIL abort_p got=%h exp=0000", p); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", done); end
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [2*W-1:0] r;
        int e, bc;
        bit h;
        run_op(8'd13, 8'd11, 1'b0, 0, 0, 1'b0, r, e, bc, h);
        tests++; if (r !== 16'h008F) begin fails++; $display("FAIL basic_p got=%h exp=008f", r); end
        tests++; if (e !== 9) begin fails++; $display("FAIL basic_latency got=%0d exp=9", e); end
        tests++; if (bc !== 9) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
        tests++; if (h !== 1'b1) begin fails++; $display("FAIL basic_p_held got=%b exp=1", h); end
        start = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (done !== 1'b1 || p !== 16'h008F) begin
            fails++; $display("FAIL done_level done=%b p=%h exp=1,008f", done, p);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ta [8] = '{8'hFF, 8'hFD, 8'h80, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h80};
        logic [W-1:0]   tb [8] = '{8'hFF, 8'h05, 8'h80, 8'h01, 8'hC8, 8'hC8, 8'h80, 8'h80};
        logic           ts [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] te [8] = '{16'hFE01, 16'hFFF1, 16'h4000, 16'hFF80,
                                   16'h0000, 16'h0000, 16'hC080, 16'h4000};
        logic [2*W-1:0] r;
        int e, bc;
        bit h;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], 0, 0, 1'b0, r, e, bc, h);
            tests++; if (r !== te[i] || e !== 9) begin
                fails++;
                $display("FAIL corner_%0d x=%h y=%h s=%b got=%h lat=%0d exp=%h lat=9",
                         i, ta[i], tb[i], ts[i], r, e, te[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [2*W-1:0] r;
        int e, bc;
        bit h;
        run_op(8'd37, 8'd201, 1'b0, 2, 5, 1'b0, r, e, bc, h);
        tests++; if (r !== 16'h1D0D || e !== 9) begin
            fails++; $display("FAIL ignore_start_u got=%h lat=%0d exp=1d0d lat=9", r, e);
        end
        run_op(8'hE7, 8'h19, 1'b1, 2, 5, 1'b0, r, e, bc, h);
        tests++; if (r !== model(8'hE7, 8'h19, 1'b1) || e !== 9) begin
            fails++; $display("FAIL ignore_start_s got=%h lat=%0d exp=%h lat=9",
                              r, e, model(8'hE7, 8'h19, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] r1, r2;
        int e1, e2, bc;
        bit h1, h2;
        run_op(8'd123, 8'd45, 1'b0, 0, 0, 1'b1, r1, e1, bc, h1);
        tests++; if (r1 !== 16'h159F) begin fails++; $display("FAIL b2b_first got=%h exp=159f", r1); end
        // start is still high here: the second op is accepted straight out of DONE.
        run_op(8'd0, 8'd200, 1'b0, 0, 0, 1'b0, r2, e2, bc, h2);
        tests++; if (h2 !== 1'b1) begin fails++; $display("FAIL b2b_p_held got=%b exp=1", h2); end
        tests++; if (r2 !== 16'h0000 || e2 !== 9) begin
            fails++; $display("FAIL b2b_second got=%h lat=%0d exp=0000 lat=9", r2, e2);
        end
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        logic           sm;
        logic [2*W-1:0] r;
        int e, bc;
        bit h, hold;
        hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            sm = 1'($urandom);
            if (!hold && ($urandom_range(0, 3) == 0)) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            hold = 1'($urandom);
            run_op(a, b, sm, $urandom_range(1, 8), $urandom_range(1, 8), hold, r, e, bc, h);
            tests++; if (r !== model(a, b, sm) || e !== 9 || h !== 1'b1) begin
                fails++;
                $display("FAIL random_%0d x=%h y=%h s=%b got=%h lat=%0d held=%b exp=%h lat=9",
                         i, a, b, sm, r, e, h, model(a, b, sm));
            end
        end
        start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
